// File: rtl/regfile_param_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_bypass
// Purpose  : Parametrised register file with one byte-enabled write port, two
//            registered read ports with write/clear bypass, optional hard-wired
//            zero entry and a sequenced bulk-clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param_bypass #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [ADDR_W-1:0]     rd1_addr_i,
    input  logic [ADDR_W-1:0]     rd2_addr_i,
    output logic [DATA_W-1:0]     rd1_data_o,
    output logic [DATA_W-1:0]     rd2_data_o,
    input  logic                  clear_i,
    output logic                  busy_o
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd1_q;
    logic [DATA_W-1:0]   rd2_q;
    logic [DATA_W-1:0]   rd1_d;
    logic [DATA_W-1:0]   rd2_d;

    logic                w_busy;
    logic                w_wr_fire;
    logic [DATA_W-1:0]   w_wr_merged;

    assign w_busy    = (state_q == ST_CLEAR);
    assign w_wr_fire = wr_en_i && !w_busy && !((ZERO_REG != 0) && (wr_addr_i == '0));

    for (genvar k = 0; k < NBYTES; k++) begin : g_byte
        assign w_wr_merged[8*k +: 8] = wr_be_i[k] ? wr_data_i[8*k +: 8]
                                                  : mem_q[wr_addr_i][8*k +: 8];
    end

    // Read next-state reflects this edge's write or clear so no stale data escapes.
    always_comb begin
        rd1_d = mem_q[rd1_addr_i];
        if (w_wr_fire && (wr_addr_i == rd1_addr_i)) rd1_d = w_wr_merged;
        if (w_busy && (ptr_q == rd1_addr_i))        rd1_d = '0;
        if ((ZERO_REG != 0) && (rd1_addr_i == '0))  rd1_d = '0;

        rd2_d = mem_q[rd2_addr_i];
        if (w_wr_fire && (wr_addr_i == rd2_addr_i)) rd2_d = w_wr_merged;
        if (w_busy && (ptr_q == rd2_addr_i))        rd2_d = '0;
        if ((ZERO_REG != 0) && (rd2_addr_i == '0))  rd2_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (w_wr_fire) mem_q[wr_addr_i] <= w_wr_merged;
            if (w_busy)    mem_q[ptr_q]     <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q   <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign rd1_data_o = rd1_q;
    assign rd2_data_o = rd2_q;
    assign busy_o     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param_bypass.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param_bypass
// Purpose  : Self-checking bench for regfile_param_bypass (ZERO_REG=0 and =1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_param_bypass;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [3:0]  wr_addr_i = '0;
    logic [1:0]  wr_be_i = '0;
    logic [15:0] wr_data_i = '0;
    logic [3:0]  rd1_addr_i = '0;
    logic [3:0]  rd2_addr_i = '0;
    logic        clear_i = 1'b0;

    logic [15:0] r1_0, r2_0, r1_z, r2_z;
    logic        b_0, b_z;

    always #5 clk_i = ~clk_i;

    regfile_param_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_be_i(wr_be_i), .wr_data_i(wr_data_i), .rd1_addr_i(rd1_addr_i),
        .rd2_addr_i(rd2_addr_i), .rd1_data_o(r1_0), .rd2_data_o(r2_0),
        .clear_i(clear_i), .busy_o(b_0)
    );

    regfile_param_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dutz (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_be_i(wr_be_i), .wr_data_i(wr_data_i), .rd1_addr_i(rd1_addr_i),
        .rd2_addr_i(rd2_addr_i), .rd1_data_o(r1_z), .rd2_data_o(r2_z),
        .clear_i(clear_i), .busy_o(b_z)
    );

    int checks = 0;
    int errors = 0;

    // Reference: two plain arrays (index 1 = zero-entry variant) plus clear progress.
    logic [15:0] m_mem [2][16];
    logic        m_busy;
    int          m_ptr;
    logic [15:0] e_rd1 [2];
    logic [15:0] e_rd2 [2];

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] ez1;
        logic [15:0] ez2;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 16; i++) m_mem[z][i] = '0;
        m_busy = 1'b0;
        m_ptr  = 0;
    endtask

    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (wr_en_i && !m_busy && !(z == 1 && wr_addr_i == 4'd0)) begin
                for (int k = 0; k < 2; k++)
                    if (wr_be_i[k]) m_mem[z][wr_addr_i][8*k +: 8] = wr_data_i[8*k +: 8];
            end
        end
        if (m_busy) begin
            for (int z = 0; z < 2; z++) m_mem[z][m_ptr] = '0;
            if (m_ptr == 15) begin
                m_busy = 1'b0;
                m_ptr  = 0;
            end else begin
                m_ptr++;
            end
        end else if (clear_i) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end
        for (int z = 0; z < 2; z++) begin
            e_rd1[z] = (z == 1 && rd1_addr_i == 4'd0) ? 16'h0 : m_mem[z][rd1_addr_i];
            e_rd2[z] = (z == 1 && rd2_addr_i == 4'd0) ? 16'h0 : m_mem[z][rd2_addr_i];
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_i);
        model_edge();
        #1;
        chk($sformatf("%s rd1", tag), r1_0, e_rd1[0]);
        chk($sformatf("%s rd2", tag), r2_0, e_rd2[0]);
        chk($sformatf("%s rd1_z", tag), r1_z, e_rd1[1]);
        chk($sformatf("%s rd2_z", tag), r2_z, e_rd2[1]);
        chk($sformatf("%s busy", tag), {15'd0, b_0}, {15'd0, m_busy});
        chk($sformatf("%s busy_z", tag), {15'd0, b_z}, {15'd0, m_busy});
    endtask

    task automatic idle_inputs();
        wr_en_i = 1'b0; wr_be_i = '0; wr_data_i = '0; clear_i = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        rst_ni = 1'b0;
        #1;
        chk({tag, " rd1"}, r1_0, 16'h0);
        chk({tag, " rd2"}, r2_0, 16'h0);
        chk({tag, " rd1_z"}, r1_z, 16'h0);
        chk({tag, " busy"}, {15'd0, b_0}, 16'h0);
        chk({tag, " busy_z"}, {15'd0, b_z}, 16'h0);
        model_reset();
        idle_inputs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic read_all_zero(input string tag);
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            rd1_addr_i = 4'(i);
            rd2_addr_i = 4'(15 - i);
            step(tag);
            chk($sformatf("%s entry%0d", tag, i), r1_0, 16'h0);
            chk($sformatf("%s busy idle", tag), {15'd0, b_0}, 16'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        tbl[0] = '{1'b1, 4'd6, 2'b11, 16'hABCD, 4'd6, 4'd0, 16'hABCD, 16'h0000, 16'hABCD, 16'h0000};
        tbl[1] = '{1'b1, 4'd6, 2'b10, 16'h1200, 4'd6, 4'd6, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD};
        tbl[2] = '{1'b0, 4'd6, 2'b11, 16'hFFFF, 4'd6, 4'd3, 16'h12CD, 16'h0000, 16'h12CD, 16'h0000};
        tbl[3] = '{1'b1, 4'd3, 2'b11, 16'h0040, 4'd3, 4'd3, 16'h0040, 16'h0040, 16'h0040, 16'h0040};
        tbl[4] = '{1'b1, 4'd0, 2'b11, 16'hFFFF, 4'd0, 4'd3, 16'hFFFF, 16'h0040, 16'h0000, 16'h0040};
        tbl[5] = '{1'b1, 4'd0, 2'b00, 16'h1234, 4'd0, 4'd6, 16'hFFFF, 16'h12CD, 16'h0000, 16'h12CD};
        tbl[6] = '{1'b1, 4'd0, 2'b01, 16'h0012, 4'd0, 4'd0, 16'hFF12, 16'hFF12, 16'h0000, 16'h0000};

        model_reset();
        for (int i = 0; i < 16; i++) m_mem[0][i] = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset rd1", r1_0, 16'h0);
        chk("reset rd2", r2_0, 16'h0);
        chk("reset busy", {15'd0, b_0}, 16'h0);
        rst_ni = 1'b1;

        // Directed vectors: byte enables, bypass, zero entry
        for (int v = 0; v < 7; v++) begin
            wr_en_i = tbl[v].we; wr_addr_i = tbl[v].wa; wr_be_i = tbl[v].be;
            wr_data_i = tbl[v].wd; rd1_addr_i = tbl[v].a1; rd2_addr_i = tbl[v].a2;
            clear_i = 1'b0;
            step($sformatf("vec%0d", v));
            chk($sformatf("vec%0d tbl rd1", v), r1_0, tbl[v].e1);
            chk($sformatf("vec%0d tbl rd2", v), r2_0, tbl[v].e2);
            chk($sformatf("vec%0d tbl rd1_z", v), r1_z, tbl[v].ez1);
            chk($sformatf("vec%0d tbl rd2_z", v), r2_z, tbl[v].ez2);
        end

        // Randomised traffic against the reference
        for (int n = 0; n < 300; n++) begin
            wr_en_i    = 1'($urandom);
            wr_addr_i  = 4'($urandom);
            wr_be_i    = 2'($urandom);
            wr_data_i  = 16'($urandom);
            rd1_addr_i = (n % 5 == 0) ? wr_addr_i : 4'($urandom);
            rd2_addr_i = 4'($urandom);
            clear_i    = ($urandom_range(0, 24) == 0);
            step("rand");
        end
        idle_inputs();
        repeat (17) step("drain");

        // Mid-cycle asynchronous reset, then every entry must read 0
        async_reset_check("async_rst");
        read_all_zero("after_rst");

        // Bulk clear with a same-cycle write, dropped writes and ignored re-pulses
        for (int i = 0; i < 16; i++) begin
            wr_en_i = 1'b1; wr_addr_i = 4'(i); wr_be_i = 2'b11; wr_data_i = 16'h5555;
            rd1_addr_i = 4'(i); rd2_addr_i = 4'(i);
            step("fill");
        end
        wr_en_i = 1'b1; wr_addr_i = 4'd2; wr_data_i = 16'h1234; clear_i = 1'b1;
        rd1_addr_i = 4'd2; rd2_addr_i = 4'd0;
        step("clr_start");
        chk("clr_start same-cycle write", r1_0, 16'h1234);
        busy_cnt = b_0 ? 1 : 0;
        for (int j = 1; j < 24; j++) begin
            wr_en_i    = (j < 15) ? 1'($urandom) : 1'b0;
            wr_addr_i  = 4'($urandom);
            wr_be_i    = 2'($urandom);
            wr_data_i  = 16'($urandom);
            clear_i    = (j < 15) ? 1'($urandom) : 1'b0;
            rd1_addr_i = 4'(j - 1);
            rd2_addr_i = 4'($urandom);
            step("clearing");
            if (b_0) busy_cnt++;
        end
        chk("clear busy cycles", 16'(busy_cnt), 16'd16);
        read_all_zero("after_clear");

        // Reset during a clear aborts it and leaves the array zeroed
        for (int i = 0; i < 16; i++) begin
            wr_en_i = 1'b1; wr_addr_i = 4'(i); wr_be_i = 2'b11;
            wr_data_i = 16'($urandom) | 16'h0101;
            step("refill");
        end
        idle_inputs();
        clear_i = 1'b1;
        step("clr2_start");
        clear_i = 1'b0;
        repeat (4) step("clr2_run");
        async_reset_check("mid_clear_rst");
        read_all_zero("after_mid_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
